// File: rtl/datamem_pkg.sv
// Shared constants for the datamem data memory: default geometry, reset word
// and the read/write select encoding.
package datamem_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 16;

  localparam logic [31:0] RESET_WORD = 32'h0;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

endpackage

// File: rtl/datamem_array.sv
// Single-port word storage with a per-word valid bit that is cleared asynchronously,
// so a freshly reset memory reads as zero without clearing the data words.
module datamem_array
  import datamem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Data words carry no reset; the valid bit alone decides what a read returns.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[addr] <= wdata;
  end

  assign rdata = valid_q[addr] ? mem_q[addr] : DATA_W'(RESET_WORD);

endmodule

// File: rtl/datamem.sv
// Word-addressed data memory for load/store: address decode plus registered read data.
// Build option DATAMEM_WRITE_THROUGH_EN: a store also drives its data onto dataOut.
module datamem
  import datamem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Ina,
  input  logic [DATA_W-1:0] Inb,
  input  logic              enable,
  input  logic              readwrite,
  output logic [DATA_W-1:0] dataOut
);

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  // Upper address bits alias onto the decoded range.
  assign addr = Ina[ADDR_W-1:0];
  assign we   = enable && (readwrite == RW_WRITE);

  generate
    if (ADDR_W < 32) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^Ina[31:ADDR_W];
    end
  endgenerate

  datamem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .wdata(Inb),
    .rdata(rd_data)
  );

  always_comb begin
    dout_d = dout_q;
    if (enable) begin
      if (readwrite == RW_READ) begin
        dout_d = rd_data;
      end
`ifdef DATAMEM_WRITE_THROUGH_EN
      else begin
        dout_d = Inb;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= DATA_W'(RESET_WORD);
    else     dout_q <= dout_d;
  end

  assign dataOut = dout_q;

endmodule

// File: tb/tb_datamem.sv
// Randomised bench for datamem against an associative-array memory model,
// plus directed scenarios with literal expectations.
module tb_datamem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Ina = '0;
  logic [31:0] Inb = '0;
  logic        enable = 1'b0;
  logic        readwrite = 1'b0;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [int unsigned];
  logic [31:0] exp_out = '0;

  datamem dut (
    .clk      (clk),
    .rst      (rst),
    .Ina      (Ina),
    .Inb      (Inb),
    .enable   (enable),
    .readwrite(readwrite),
    .dataOut  (dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int unsigned k;
    k = a & 32'h0000FFFF;
    return mdl.exists(k) ? mdl[k] : 32'h0;
  endfunction

  // Reference behaviour: reset empties the memory, reads return stored word or 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl.delete();
      exp_out = 32'h0;
    end else if (enable) begin
      if (!readwrite) begin
        exp_out = mdl_read(Ina);
      end else begin
        mdl[Ina & 32'h0000FFFF] = Inb;
`ifdef DATAMEM_WRITE_THROUGH_EN
        exp_out = Inb;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dataOut !== exp_out) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dataOut=%h expected=%h", $time, dataOut, exp_out);
      end
    end
  end

  task automatic step(input logic en, input logic rw, input logic [31:0] a, input logic [31:0] d);
    enable = en;
    readwrite = rw;
    Ina = a;
    Inb = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] want);
    checks++;
    if (dataOut !== want || exp_out !== want) begin
      errors++;
      $display("FAIL %s dataOut=%h model=%h expected=%h", name, dataOut, exp_out, want);
    end
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 lit("async_rst_immediate", 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lit("reset_state", 32'h0);
    chk_en = 1'b1;

    step(1, 0, 32'h1, 32'h0);              lit("read_after_reset", 32'h0);
    step(1, 1, 32'h0, 32'hFFFFFFFF);
    step(1, 0, 32'h0, 32'h0);              lit("write_then_read", 32'hFFFFFFFF);
    step(1, 0, 32'h1, 32'h0);              lit("no_bleed", 32'h0);

    step(1, 1, 32'h5, 32'h5);
    step(1, 0, 32'h5, 32'h0);              lit("read_addr5", 32'h5);
    step(1, 1, 32'h5, 32'h12345678);
`ifdef DATAMEM_WRITE_THROUGH_EN
    lit("write_through", 32'h12345678);
`else
    lit("hold_on_write", 32'h5);
`endif
    step(1, 0, 32'h5, 32'h0);              lit("read_new_addr5", 32'h12345678);

    step(0, 1, 32'h2, 32'hDEADBEEF);       lit("idle_hold", 32'h12345678);
    step(1, 0, 32'h2, 32'h0);              lit("idle_no_write", 32'h0);

    step(1, 1, 32'h0001FFFF, 32'hA5A5A5A5);
    step(1, 0, 32'h0000FFFF, 32'h0);       lit("alias_top_addr", 32'hA5A5A5A5);

    step(1, 1, 32'h0, 32'h11111111);
    step(1, 1, 32'h3, 32'h33333333);
    step(1, 0, 32'h3, 32'h0);              lit("pre_reset_read", 32'h33333333);
    pulse_rst();
    step(1, 0, 32'h0, 32'h0);              lit("post_reset_addr0", 32'h0);
    step(1, 0, 32'h3, 32'h0);              lit("post_reset_addr3", 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0} & 32'hFFFF0000;
      a = a | ($urandom_range(0, 3) == 0 ? 32'h0000FFF0 + $urandom_range(0, 15) : $urandom_range(0, 15));
      step(($urandom_range(0, 4) != 0), $urandom_range(0, 1), a, $urandom());
      if ($urandom_range(0, 199) == 0) pulse_rst();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamem.md
Name: datamem

Overview:
- Word-addressed 32-bit data memory for the single-cycle processor; serves load-word and store-word instructions from the execute stage.
- ALU result drives the address; rt register value drives the store data.
- Synchronous read and write on the rising clock edge; one shared enable plus a read/write select.
- Asynchronous reset makes every word read back as zero.

Parameters:
- DATA_W, 32, width of each memory word and of both data paths.
- ADDR_W, 16, number of address bits decoded; depth is 2**ADDR_W words (65536 by default).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- Ina  input  32  word address; only Ina[ADDR_W-1:0] is decoded, upper bits ignored.
- Inb  input  DATA_W  store data.
- enable  input  1  access enable; no read or write when low.
- readwrite  input  1  0 = read (load word), 1 = write (store word).
- dataOut  output  DATA_W  registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, while rst=1 and regardless of clk:
  - dataOut = 0.
  - Every word is logically cleared and reads as 0 after reset.
  - Implementation uses a per-word valid bit cleared asynchronously; a word with valid=0 reads as 0.
  - Writes and reads are blocked while rst=1.
- Read, at posedge clk with enable=1 and readwrite=0:
  - dataOut <= mem[Ina[ADDR_W-1:0]], or 0 if that word is not valid.
  - Latency is 1 cycle; data is visible after the edge.
- Write, at posedge clk with enable=1 and readwrite=1:
  - mem[addr] <= Inb and valid[addr] <= 1.
  - dataOut holds its previous value.
- Idle (enable=0): memory and dataOut hold.
- Back-to-back cycles: a write followed by a read of the same address on the next edge returns the new data. No same-edge forwarding is needed because one edge performs only one access.
- Address aliasing: addresses differing only in bits at or above ADDR_W map to the same word.
- Reset mid-operation: asynchronous clear wins immediately. A write in progress on an edge where rst=1 is discarded.
- X on enable/readwrite is not supported; the bench always drives them to known values.

Optional Feature:
- Macro DATAMEM_WRITE_THROUGH_EN.
- Defined: on a write cycle dataOut <= Inb on the same edge, so stored data is observable without a follow-up load.
- Undefined: dataOut holds on writes, as specified above.

Decomposition:
- Package datamem_pkg holds:
  - localparams DATA_W_DEFAULT=32 and ADDR_W_DEFAULT=16.
  - RESET_WORD=32'h0.
  - enum/constants RW_READ=1'b0 and RW_WRITE=1'b1.
- One sub-module, datamem_array: storage array plus valid-bit vector with async clear, single read/write port.
- The top level (datamem) holds decode and the dataOut register.

Test Plan:
- Reset then read: rst=1 for 2 cycles, rst=0; read addr 1 → dataOut=0x00000000 after one edge.
- Write then read: write 0xFFFFFFFF to addr 0; read addr 0 → 0xFFFFFFFF; read addr 1 → 0x00000000 (no bleed-through).
- Hold on write: read addr 5 holding value 0x5, then write 0x12345678 to addr 5 → dataOut stays 0x5 (write-through off), next read → 0x12345678. With DATAMEM_WRITE_THROUGH_EN defined → dataOut=0x12345678 right after the write.
- Enable low: enable=0, readwrite=1, Inb=0xDEADBEEF, addr 2 → later read of addr 2 returns 0; dataOut unchanged during the idle cycle.
- Aliasing and top address: write 0xA5A5A5A5 to addr 0x0001FFFF → read addr 0x0000FFFF returns 0xA5A5A5A5.
- Async reset mid-run: after writes to addrs 0 and 3, pulse rst between edges → dataOut=0 immediately; reads of addrs 0 and 3 return 0.
